fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
IF stage plus IF/ID pipeline register of the 5-stage RV32I core.
- Owns the PC and issues instruction-memory requests over a req/gnt/rvalid handshake.
- Delivers InstrD/PCD/PCPlus4D to decode.
- Obeys StallF/StallD/FlushD and the PCSrcE/PCTargetE redirect from the conflict prevention logic and execute stage.
- Allows at most one outstanding memory request; discards stale responses after a redirect.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset.
NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0).

Ports:
clk  in  1  core clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
StallF  in  1  hold PC / fetch buffer
StallD  in  1  hold IF/ID register
FlushD  in  1  replace IF/ID contents with bubble
PCSrcE  in  1  redirect taken in execute
PCTargetE  in  32  redirect target
IMemReq  out  1  request valid
IMemAddr  out  32  request address (word aligned)
IMemGnt  in  1  request accepted this cycle
IMemRValid  in  1  response data valid
IMemRData  in  32  response instruction
InstrD  out  32  decode instruction
PCD  out  32  decode PC
PCPlus4D  out  32  decode PC+4
ValidD  out  1  InstrD is a real instruction
FetchBusyF  out  1  no instruction available at F this cycle

Behaviour:
Reset (rst_n=0 at edge):
- PCF=RESET_PC, state=IDLE, kill=0, buffer empty.
- InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0, IMemReq=0.

FSM states:
- IDLE: no request outstanding. Next cycle raise IMemReq with IMemAddr=PCF -> REQ.
- REQ: IMemReq=1, IMemAddr=PCF held stable until IMemGnt. On gnt -> WAIT. Request may not be withdrawn except on redirect (then the address changes to the target; req stays high).
- WAIT: IMemReq=0, await IMemRValid.
  - Response with kill=0 -> instruction available.
  - Response with kill=1 -> discard, clear kill, re-issue at the current PCF -> REQ.
- HOLD: instruction buffered because decode is stalled. Leave when the instruction is consumed.

Fetch rules:
- Instruction available in a cycle = rvalid arrived in WAIT with kill=0, or the buffer is full (HOLD).
- FetchBusyF = !available.
- Consume occurs when available && !StallD && !FlushD && !PCSrcE.
- On consume:
  - Load IF/ID: InstrD = data, PCD=PCF, PCPlus4D=PCF+4, ValidD=1.
  - PCF <= PCF+4.
  - Next state: REQ (issue the next fetch the following cycle, IMemAddr=PCF+4).
- Available but StallD=1: capture data into the buffer -> HOLD. No new request.

Redirect (PCSrcE=1), highest priority:
- PCF <= PCTargetE (mod 32).
- Buffer cleared.
- Stale handling by state:
  - WAIT without rvalid this cycle: set kill=1.
  - WAIT with rvalid this cycle: data dropped.
  - REQ: the next cycle presents the new address.
  - IDLE or HOLD: -> REQ.

IF/ID register priority: FlushD > StallD > load.
- FlushD: InstrD=NOP_INSTR, ValidD=0 (PCD/PCPlus4D don't-care, drive 0).
- StallD: all hold.
- Else load on consume. When not consuming: bubble (NOP_INSTR, ValidD=0).

Other rules:
- StallF and StallD are coincident by design. A PC update requires consume, so StallF=1 never advances PC except via redirect.
- PC arithmetic is 32-bit wraparound: 32'hFFFF_FFFC+4 = 0.
- IMemAddr[1:0] always 0. PCTargetE[1:0] is ignored (forced 0).

Decomposition:
riscv_pkg:
- NOP_INSTR.
- fetch_state_t enum {IDLE, REQ, WAIT, HOLD}.
- XLEN=32.

Sub-module if_id_reg: the IF/ID register with flush/stall/load priority. fetch_unit instantiates it.

Test Plan:
1. Reset release, memory always gnt with 1-cycle rvalid -> IMemAddr 0x0, 0x4, 0x8…; InstrD sequence matches memory; ValidD=1 every other cycle (gnt/wait cadence), bubbles ValidD=0 with NOP 0x13 in between.
2. StallD=StallF=1 for 3 cycles while an instruction arrives -> state HOLD, no IMemReq, InstrD frozen; on release the buffered instruction loads with PCD of the held PC and the next fetch is at PC+4.
3. PCSrcE=1, PCTargetE=0x100 while in WAIT; rvalid 2 cycles later with data 0xDEADBEEF -> data discarded (never reaches InstrD), next request at 0x100, first ValidD=1 shows PCD=0x100.
4. PCSrcE=1 and StallD=1 and FlushD=1 in the same cycle -> InstrD=0x13, ValidD=0; PCF=target next cycle.
5. IMemGnt delayed 4 cycles -> IMemAddr stable through REQ, FetchBusyF=1, ValidD=0 throughout.
6. PCTargetE=0xFFFF_FFFC -> fetch there, then IMemAddr=0x0 (wrap); assert rst_n=0 mid-WAIT -> all outputs at reset values, the late rvalid is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and fetch FSM state encoding for the RV32I core.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register; flush beats stall beats load, idle cycles insert a bubble.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] BUBBLE = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_flush,
    input  logic            i_stall,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_instr,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_pc_plus4,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_valid
);
    logic [XLEN-1:0] r_instr, r_pc, r_pc_plus4;
    logic            r_valid;

    always_ff @(posedge clk) begin
        if (!rst_n || i_flush || (!i_stall && !i_load)) begin
            r_instr    <= BUBBLE;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else if (!i_stall) begin
            r_instr    <= i_instr;
            r_pc       <= i_pc;
            r_pc_plus4 <= i_pc_plus4;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;
    assign o_valid    = r_valid;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage owning the PC, one-outstanding instruction-memory fetch, and the IF/ID register.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            IMemReq,
    output logic [XLEN-1:0] IMemAddr,
    input  logic            IMemGnt,
    input  logic            IMemRValid,
    input  logic [XLEN-1:0] IMemRData,
    output logic [XLEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD,
    output logic            FetchBusyF
);
    fetch_state_t    r_state, w_next;
    logic [XLEN-1:0] r_pc, w_pc_next, r_buf, w_buf_next, w_data, w_pc_plus4;
    logic            r_kill, w_kill_next, w_avail, w_consume;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_avail    = (r_state == WAIT && IMemRValid && !r_kill) || r_state == HOLD;
    assign w_data     = (r_state == HOLD) ? r_buf : IMemRData;
    assign w_consume  = w_avail && !StallF && !StallD && !FlushD && !PCSrcE;
    assign IMemReq    = r_state == REQ;
    assign IMemAddr   = r_pc;
    assign FetchBusyF = !w_avail;

    always_comb begin
        w_next      = r_state;
        w_pc_next   = r_pc;
        w_kill_next = r_kill;
        w_buf_next  = r_buf;
        if (PCSrcE) begin
            // an in-flight response must be dropped when it lands, so stay in WAIT with kill set
            w_pc_next   = PCTargetE & ~32'h3;
            w_buf_next  = '0;
            w_kill_next = r_state == WAIT && !IMemRValid;
            w_next      = w_kill_next ? WAIT : REQ;
        end else if (w_consume) begin
            w_pc_next = w_pc_plus4;
            w_next    = REQ;
        end else if (w_avail) begin
            w_buf_next = w_data;
            w_next     = HOLD;
        end else if (r_state == IDLE) begin
            w_next = REQ;
        end else if (r_state == REQ && IMemGnt) begin
            w_next = WAIT;
        end else if (r_state == WAIT && IMemRValid) begin
            w_kill_next = 1'b0;
            w_next      = REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC & ~32'h3;
            r_kill  <= 1'b0;
            r_buf   <= '0;
        end else begin
            r_state <= w_next;
            r_pc    <= w_pc_next;
            r_kill  <= w_kill_next;
            r_buf   <= w_buf_next;
        end
    end

    if_id_reg #(.BUBBLE(NOP_INSTR)) u_if_id (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (FlushD),
        .i_stall   (StallD),
        .i_load    (w_consume),
        .i_instr   (w_data),
        .i_pc      (r_pc),
        .i_pc_plus4(w_pc_plus4),
        .o_instr   (InstrD),
        .o_pc      (PCD),
        .o_pc_plus4(PCPlus4D),
        .o_valid   (ValidD)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed cycle-by-cycle bench; memory handshake driven by hand each cycle.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n, StallF, StallD, FlushD, PCSrcE, IMemGnt, IMemRValid;
    logic [31:0] PCTargetE, IMemRData;
    logic        IMemReq, ValidD, FetchBusyF;
    logic [31:0] IMemAddr, InstrD, PCD, PCPlus4D;
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .IMemGnt(IMemGnt), .IMemRValid(IMemRValid), .IMemRData(IMemRData),
        .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD), .FetchBusyF(FetchBusyF)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hA000_0000 + a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // drive one cycle's inputs at the falling edge, then let combinational outputs settle
    task automatic drv(input logic g, input logic rv, input logic [31:0] rd,
                       input logic s, input logic f, input logic p, input logic [31:0] t);
        @(negedge clk);
        IMemGnt = g; IMemRValid = rv; IMemRData = rd;
        StallF = s; StallD = s; FlushD = f; PCSrcE = p; PCTargetE = t;
        #1;
    endtask

    task automatic chk_id(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] pc4, input logic v);
        chk({tag, "_instr"}, InstrD, instr);
        chk({tag, "_pcd"}, PCD, pc);
        chk({tag, "_pc4"}, PCPlus4D, pc4);
        chk({tag, "_valid"}, {31'b0, ValidD}, {31'b0, v});
    endtask

    initial begin
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk_id("reset", 32'h13, 0, 0, 0);
        chk("reset_req", {31'b0, IMemReq}, 0);
        chk("reset_busy", {31'b0, FetchBusyF}, 1);
        rst_n = 1'b1;
        // sequential fetch with immediate grant and one-cycle response
        drv(1, 0, 0, 0, 0, 0, 0);
        chk("t1_req0", {31'b0, IMemReq}, 1);
        chk("t1_addr0", IMemAddr, 0);
        drv(0, 1, mem(0), 0, 0, 0, 0);
        chk("t1_busy_resp", {31'b0, FetchBusyF}, 0);
        chk("t1_req_wait", {31'b0, IMemReq}, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        chk_id("t1_i0", mem(0), 0, 4, 1);
        chk("t1_addr4", IMemAddr, 4);
        drv(0, 1, mem(4), 0, 0, 0, 0);
        chk_id("t1_bubble", 32'h13, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        chk_id("t1_i1", mem(4), 4, 8, 1);
        chk("t1_addr8", IMemAddr, 8);
        // decode stall while an instruction arrives
        drv(0, 1, mem(8), 1, 0, 0, 0);
        chk("t2_busy_arrive", {31'b0, FetchBusyF}, 0);
        drv(0, 0, 0, 1, 0, 0, 0);
        chk("t2_req_hold1", {31'b0, IMemReq}, 0);
        chk("t2_busy_hold", {31'b0, FetchBusyF}, 0);
        chk_id("t2_frozen", 32'h13, 0, 0, 0);
        drv(0, 0, 0, 1, 0, 0, 0);
        chk("t2_req_hold2", {31'b0, IMemReq}, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("t2_req_release", {31'b0, IMemReq}, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        chk_id("t2_load", mem(8), 8, 12, 1);
        chk("t2_addr12", IMemAddr, 12);
        chk("t2_req", {31'b0, IMemReq}, 1);
        // redirect while waiting; late response must be discarded
        drv(0, 0, 0, 0, 0, 1, 32'h100);
        chk("t3_busy", {31'b0, FetchBusyF}, 1);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk("t3_req_wait", {31'b0, IMemReq}, 0);
        chk("t3_valid_wait", {31'b0, ValidD}, 0);
        drv(0, 1, 32'hDEAD_BEEF, 0, 0, 0, 0);
        chk("t3_busy_killed", {31'b0, FetchBusyF}, 1);
        drv(1, 0, 0, 0, 0, 0, 0);
        chk("t3_addr", IMemAddr, 32'h100);
        chk("t3_req", {31'b0, IMemReq}, 1);
        chk_id("t3_no_stale", 32'h13, 0, 0, 0);
        drv(0, 1, mem(32'h100), 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        chk_id("t3_first", mem(32'h100), 32'h100, 32'h104, 1);
        chk("t3_addr104", IMemAddr, 32'h104);
        // redirect, stall and flush together while a response lands
        drv(0, 1, mem(32'h104), 1, 1, 1, 32'h200);
        drv(1, 0, 0, 0, 0, 0, 0);
        chk_id("t4_flush", 32'h13, 0, 0, 0);
        chk("t4_addr", IMemAddr, 32'h200);
        chk("t4_req", {31'b0, IMemReq}, 1);
        // grant withheld for four cycles
        drv(0, 1, mem(32'h200), 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0);
        chk_id("t5_i", mem(32'h200), 32'h200, 32'h204, 1);
        chk("t5_addr_first", IMemAddr, 32'h204);
        for (int i = 0; i < 3; i++) begin
            drv(0, 0, 0, 0, 0, 0, 0);
            chk("t5_addr_stable", IMemAddr, 32'h204);
            chk("t5_req_stable", {31'b0, IMemReq}, 1);
            chk("t5_busy", {31'b0, FetchBusyF}, 1);
            chk("t5_valid", {31'b0, ValidD}, 0);
        end
        drv(1, 0, 0, 0, 0, 0, 0);
        chk("t5_addr_gnt", IMemAddr, 32'h204);
        drv(0, 1, mem(32'h204), 0, 0, 0, 0);
        // redirect to the top word (low bits ignored), then wrap to zero
        drv(0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF);
        chk_id("t6_prev", mem(32'h204), 32'h204, 32'h208, 1);
        drv(1, 0, 0, 0, 0, 0, 0);
        chk("t6_addr_top", IMemAddr, 32'hFFFF_FFFC);
        chk("t6_req_top", {31'b0, IMemReq}, 1);
        drv(0, 1, 32'h1234_5678, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, 0, 0);
        chk_id("t6_top", 32'h1234_5678, 32'hFFFF_FFFC, 32'h0, 1);
        chk("t6_addr_wrap", IMemAddr, 0);
        // reset mid-wait; the late response must be ignored
        drv(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        drv(0, 1, 32'hCAFE_F00D, 0, 0, 0, 0);
        chk_id("t6_rst", 32'h13, 0, 0, 0);
        chk("t6_rst_req", {31'b0, IMemReq}, 0);
        chk("t6_rst_busy", {31'b0, FetchBusyF}, 1);
        rst_n = 1'b1;
        drv(1, 0, 0, 0, 0, 0, 0);
        chk("t6_post_addr", IMemAddr, 0);
        chk("t6_post_req", {31'b0, IMemReq}, 1);
        chk_id("t6_post_id", 32'h13, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
